// File: rtl/ikaz_surucu.sv
// Warning driver: turns lamp and audible warning requests into physical lamp and buzzer drive.
// The lamps blink on their own, and a small state machine sequences the buzzer and handles muting and timeout.
module ikaz_surucu #(
  parameter int TICK_DIV   = 1000,
  parameter int BEEP_ON    = 2,
  parameter int BEEP_OFF   = 3,
  parameter int KEMER_SURE = 60,
  parameter int BLINK      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       emniyet_kemeri_lambasi,
  input  logic       kapi_lambasi,
  input  logic       emniyet_kemeri_ikaz,
  input  logic       kapi_ikaz,
  input  logic       susturma,
  output logic       kemer_lamba,
  output logic       kapi_lamba,
  output logic       buzzer,
  output logic [1:0] ikaz_durum
);

  localparam int TW     = $clog2(TICK_DIV);
  localparam int PERIOD = BEEP_ON + BEEP_OFF;
  localparam int PW     = $clog2(PERIOD + 1);
  localparam int SW     = $clog2(KEMER_SURE + 1);
  localparam int BW     = $clog2(BLINK + 1);

  typedef enum logic [1:0] {
    BOSTA      = 2'd0,
    KAPI_IKAZ  = 2'd1,
    KEMER_IKAZ = 2'd2,
    SUSTURULDU = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [SW-1:0]   timeout_q, timeout_d;
  logic            buzzer_q, buzzer_d;
  logic [1:0]      blink_act_q, blink_act_d;
  logic [1:0]      blink_lvl_q, blink_lvl_d;
  logic [1:0]      lamp_q, lamp_d;
  logic [BW-1:0]   blink_cnt_q [2];
  logic [BW-1:0]   blink_cnt_d [2];
  logic [1:0]      lamp_req, lamp_ikaz;
  logic            tick, entry, timeout_sat, timeout_hit;
  logic [PW-1:0]   phase_last;

  assign lamp_req  = {kapi_lambasi, emniyet_kemeri_lambasi};
  assign lamp_ikaz = {kapi_ikaz, emniyet_kemeri_ikaz};

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Timeout fires on the tick that brings the elapsed count up to KEMER_SURE.
  always_comb begin
    timeout_sat = (timeout_q == SW'(KEMER_SURE));
    timeout_hit = timeout_sat || (tick && (timeout_q == SW'(KEMER_SURE - 1)));

    state_d = state_q;
    if (kapi_ikaz) begin
      state_d = KAPI_IKAZ;
    end else begin
      case (state_q)
        BOSTA:      if (emniyet_kemeri_ikaz) state_d = KEMER_IKAZ;
        KAPI_IKAZ:  state_d = emniyet_kemeri_ikaz ? KEMER_IKAZ : BOSTA;
        KEMER_IKAZ: begin
          if (!emniyet_kemeri_ikaz)           state_d = BOSTA;
          else if (susturma || timeout_hit)   state_d = SUSTURULDU;
        end
        SUSTURULDU: if (!emniyet_kemeri_ikaz) state_d = BOSTA;
        default:    state_d = BOSTA;
      endcase
    end
  end

  // Phase and timeout restart on every state change so each pattern begins in its on-phase.
  always_comb begin
    entry      = (state_d != state_q);
    phase_last = (state_q == KAPI_IKAZ) ? PW'(1) : PW'(PERIOD - 1);

    phase_d = phase_q;
    if (entry)     phase_d = '0;
    else if (tick) phase_d = (phase_q == phase_last) ? '0 : phase_q + PW'(1);

    timeout_d = timeout_q;
    if (entry)                     timeout_d = '0;
    else if (tick && !timeout_sat) timeout_d = timeout_q + SW'(1);

    buzzer_d = 1'b0;
    case (state_d)
      KAPI_IKAZ:  buzzer_d = (phase_d == '0);
      KEMER_IKAZ: buzzer_d = (phase_d < PW'(BEEP_ON));
      default:    buzzer_d = 1'b0;
    endcase
  end

  // Each lamp blinks from its own counter, restarting lit whenever blinking begins.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      blink_act_d[i] = lamp_req[i] & lamp_ikaz[i];
      blink_cnt_d[i] = blink_cnt_q[i];
      blink_lvl_d[i] = blink_lvl_q[i];
      if (!blink_act_d[i] || !blink_act_q[i]) begin
        blink_cnt_d[i] = '0;
        blink_lvl_d[i] = 1'b1;
      end else if (tick) begin
        if (blink_cnt_q[i] == BW'(BLINK - 1)) begin
          blink_cnt_d[i] = '0;
          blink_lvl_d[i] = ~blink_lvl_q[i];
        end else begin
          blink_cnt_d[i] = blink_cnt_q[i] + BW'(1);
        end
      end
      lamp_d[i] = lamp_req[i] & (~lamp_ikaz[i] | blink_lvl_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= BOSTA;
      tick_cnt_q     <= '0;
      phase_q        <= '0;
      timeout_q      <= '0;
      buzzer_q       <= 1'b0;
      blink_act_q    <= '0;
      blink_lvl_q    <= '0;
      lamp_q         <= '0;
      blink_cnt_q[0] <= '0;
      blink_cnt_q[1] <= '0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      phase_q        <= phase_d;
      timeout_q      <= timeout_d;
      buzzer_q       <= buzzer_d;
      blink_act_q    <= blink_act_d;
      blink_lvl_q    <= blink_lvl_d;
      lamp_q         <= lamp_d;
      blink_cnt_q[0] <= blink_cnt_d[0];
      blink_cnt_q[1] <= blink_cnt_d[1];
    end
  end

  assign kemer_lamba = lamp_q[0];
  assign kapi_lamba  = lamp_q[1];
  assign buzzer      = buzzer_q;
  assign ikaz_durum  = state_q;

endmodule

// File: doc/ikaz_surucu.md
IKAZ_SURUCU -- requirements
Module: ikaz_surucu

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000, meaning clock cycles per time tick (min 2).
REQ-002 The block SHALL have parameter BEEP_ON, default 2, meaning seat-belt buzzer on-phase length in ticks.
REQ-003 The block SHALL have parameter BEEP_OFF, default 3, meaning seat-belt buzzer off-phase length in ticks.
REQ-004 The block SHALL have parameter KEMER_SURE, default 60, meaning seat-belt buzzer timeout in ticks.
REQ-005 The block SHALL have parameter BLINK, default 1, meaning lamp blink half-period in ticks.
REQ-006 clk  input  1  single system clock; all state updates on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 emniyet_kemeri_lambasi  input  1  seat-belt lamp request from warning logic.
REQ-009 kapi_lambasi  input  1  door lamp request.
REQ-010 emniyet_kemeri_ikaz  input  1  seat-belt audible warning request.
REQ-011 kapi_ikaz  input  1  door-open-while-moving audible warning request.
REQ-012 susturma  input  1  driver mute button, one-cycle pulse.
REQ-013 kemer_lamba  output  1  physical seat-belt lamp drive.
REQ-014 kapi_lamba  output  1  physical door lamp drive.
REQ-015 buzzer  output  1  physical buzzer drive.
REQ-016 ikaz_durum  output  2  current state code (BOSTA=0, KAPI_IKAZ=1, KEMER_IKAZ=2, SUSTURULDU=3).

Function
REQ-017 A free-running tick divider SHALL assert an internal tick for one cycle every TICK_DIV clocks; it restarts from zero on reset only.
REQ-018 The FSM SHALL have states BOSTA, KAPI_IKAZ, KEMER_IKAZ, SUSTURULDU; inputs sampled every cycle, state and all outputs registered (one-cycle latency input -> output).
REQ-019 BOSTA: kapi_ikaz=1 -> KAPI_IKAZ; else emniyet_kemeri_ikaz=1 -> KEMER_IKAZ; else stay.
REQ-020 KAPI_IKAZ has priority: from any state, kapi_ikaz=1 SHALL force KAPI_IKAZ next cycle.
REQ-021 KAPI_IKAZ: kapi_ikaz=0 -> KEMER_IKAZ if emniyet_kemeri_ikaz=1, else BOSTA; susturma ignored.
REQ-022 KEMER_IKAZ: emniyet_kemeri_ikaz=0 -> BOSTA; susturma=1 -> SUSTURULDU; elapsed ticks reaching KEMER_SURE -> SUSTURULDU.
REQ-023 SUSTURULDU: emniyet_kemeri_ikaz=0 -> BOSTA; otherwise stay (re-arm only after request drops).
REQ-024 Simultaneous susturma and emniyet_kemeri_ikaz fall in KEMER_IKAZ SHALL go to BOSTA.
REQ-025 On every state entry, tick-phase counter and timeout counter SHALL clear; patterns start in on-phase at the entry cycle.
REQ-026 buzzer: KAPI_IKAZ toggles every tick (1 on, 1 off); KEMER_IKAZ on BEEP_ON ticks then off BEEP_OFF ticks, repeating; BOSTA and SUSTURULDU 0.
REQ-027 Lamps: request input 0 -> lamp 0; request 1 and matching ikaz input 0 -> steady 1; request 1 and matching ikaz 1 -> blink, toggling every BLINK ticks, starting at 1.
REQ-028 Lamp behaviour SHALL be independent of FSM state, including SUSTURULDU (muted seat-belt warning keeps blinking).
REQ-029 Timeout counter SHALL saturate at KEMER_SURE; no wrap-around.
REQ-030 Tick counter SHALL wrap from TICK_DIV-1 to 0.

Reset
REQ-031 rst_n=0 at a rising edge SHALL set state BOSTA, all counters 0, kemer_lamba=0, kapi_lamba=0, buzzer=0, ikaz_durum=0, regardless of inputs.
REQ-032 Reset mid-warning SHALL take effect at the next edge; after release, FSM re-evaluates inputs from BOSTA.

Verification (TICK_DIV=4, BEEP_ON=2, BEEP_OFF=3, KEMER_SURE=20, BLINK=1)
REQ-033 Seat-belt: emniyet_kemeri_ikaz=1, lambasi=1 -> ikaz_durum=2 next cycle; buzzer 8 cycles high, 12 low, repeating; kemer_lamba toggles every 4 cycles.
REQ-034 Timeout: hold seat-belt request 80 cycles -> ikaz_durum=3, buzzer=0, kemer_lamba still blinking; drop request -> ikaz_durum=0.
REQ-035 Mute: susturma pulse in KEMER_IKAZ -> ikaz_durum=3 next cycle, buzzer=0; susturma pulse in KAPI_IKAZ -> no change.
REQ-036 Priority: during KEMER_IKAZ assert kapi_ikaz -> ikaz_durum=1, buzzer toggles every 4 cycles; release kapi_ikaz -> ikaz_durum=2, pattern restarts on-phase.
REQ-037 Reset: rst_n=0 during KAPI_IKAZ -> all outputs 0 next edge; release with kapi_ikaz=1 -> ikaz_durum=1 one cycle later.
